// File: rtl/delay_line_mc_pkg.sv
// Shared definitions for the multi-channel delay line.
// Holds the default geometry of the block and a depth-legality helper used
// by the top level when a new delay is requested.
package delay_line_mc_pkg;

  localparam int DL_N_DEF             = 16;
  localparam int DL_CH_DEF            = 4;
  localparam int DL_MAX_DEPTH_DEF     = 16;
  localparam int DL_DEFAULT_DEPTH_DEF = 3;

  // A requested delay is usable only inside 1..max_depth.
  function automatic logic depth_is_legal(input int unsigned depth,
                                          input int unsigned max_depth);
    logic ok;
    ok = (depth != 32'd0) && (depth <= max_depth);
    return ok;
  endfunction

endpackage

// File: rtl/delay_line_mc_ram.sv
// delay_line_ram: DEPTH x W simple dual-port storage for the delay line.
// Ports:
//   clk    in  1       write clock, rising edge
//   we     in  1       write enable
//   waddr  in  AW      write address
//   wdata  in  W       write data (all lanes packed)
//   raddr  in  AW      read address
//   rdata  out W       combinational read data
// Synchronous write, asynchronous read, no reset on the array.
module delay_line_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/delay_line_mc.sv
// delay_line_mc: multi-channel delay line with runtime-programmable depth.
// Ports:
//   clk         in  1     clock, rising edge
//   rst         in  1     asynchronous reset, active-low
//   ce          in  1     clock enable (shift needs ce && in_valid)
//   in_valid    in  1     data_in holds a sample
//   data_in     in  CH*N  lane c = data_in[c*N +: N]
//   clr         in  1     synchronous flush (highest priority)
//   depth_load  in  1     load depth_in as the new delay
//   depth_in    in  DW    requested delay, legal 1..MAX_DEPTH
//   data_out    out CH*N  delayed samples, registered
//   out_valid   out 1     pulse: data_out updated with a real sample
//   primed      out 1     level: fill has reached cur_depth
//   depth_err   out 1     pulse: illegal depth_in rejected
// All lanes share the write pointer, fill counter and depth.
module delay_line_mc
  import delay_line_mc_pkg::*;
#(
  parameter int N             = DL_N_DEF,
  parameter int CH            = DL_CH_DEF,
  parameter int MAX_DEPTH     = DL_MAX_DEPTH_DEF,
  parameter int DEFAULT_DEPTH = DL_DEFAULT_DEPTH_DEF,
  parameter int DW            = $clog2(MAX_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            in_valid,
  input  logic [CH*N-1:0] data_in,
  input  logic            clr,
  input  logic            depth_load,
  input  logic [DW-1:0]   depth_in,
  output logic [CH*N-1:0] data_out,
  output logic            out_valid,
  output logic            primed,
  output logic            depth_err
);

  localparam int AW = $clog2(MAX_DEPTH);
  localparam int W  = CH * N;
  localparam logic [DW-1:0] DEPTH_ONE   = DW'(1);
  localparam logic [DW-1:0] DEPTH_RESET = DW'(DEFAULT_DEPTH);
  localparam logic [AW-1:0] ADDR_ONE    = AW'(1);

  logic [AW-1:0] wp_r;
  logic [DW-1:0] fill_r;
  logic [DW-1:0] cur_depth_r;
  logic [W-1:0]  data_out_r;
  logic          out_valid_r;
  logic          primed_r;
  logic          depth_err_r;

  logic          shift_s;
  logic          load_ok_s;
  logic [DW-1:0] fill_inc_s;
  logic [DW-1:0] fill_next_s;
  logic [AW-1:0] rd_addr_s;
  logic [W-1:0]  rd_data_s;
  logic [W-1:0]  shift_data_s;

  delay_line_ram #(
    .DEPTH (MAX_DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (shift_s),
    .waddr (wp_r),
    .wdata (data_in),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // Next-state terms for a shift: fill saturation, read address, output mux.
  always_comb begin
    shift_s   = ce & in_valid & ~clr & ~depth_load;
    load_ok_s = depth_is_legal(32'(depth_in), MAX_DEPTH);
    fill_inc_s = fill_r + DEPTH_ONE;
    if (fill_inc_s > cur_depth_r) begin
      fill_next_s = cur_depth_r;
    end else begin
      fill_next_s = fill_inc_s;
    end
    // Oldest needed sample sits D-1 slots behind the write pointer; the
    // subtraction wraps naturally in AW bits (D==MAX_DEPTH reads wp+1).
    rd_addr_s = wp_r - AW'(cur_depth_r - DEPTH_ONE);
    // A depth of one bypasses storage, since the read happens before write.
    if (cur_depth_r == DEPTH_ONE) begin
      shift_data_s = data_in;
    end else begin
      shift_data_s = rd_data_s;
    end
  end

  // Control state and registered outputs; priority clr > depth_load > shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_r        <= '0;
      fill_r      <= '0;
      cur_depth_r <= DEPTH_RESET;
      data_out_r  <= '0;
      out_valid_r <= 1'b0;
      primed_r    <= 1'b0;
      depth_err_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      depth_err_r <= 1'b0;
      if (clr) begin
        wp_r       <= '0;
        fill_r     <= '0;
        data_out_r <= '0;
        primed_r   <= 1'b0;
      end else if (depth_load) begin
        if (load_ok_s) begin
          cur_depth_r <= depth_in;
          wp_r        <= '0;
          fill_r      <= '0;
          primed_r    <= 1'b0;
        end else begin
          depth_err_r <= 1'b1;
        end
      end else if (shift_s) begin
        wp_r        <= wp_r + ADDR_ONE;
        fill_r      <= fill_next_s;
        data_out_r  <= shift_data_s;
        out_valid_r <= (fill_inc_s >= cur_depth_r);
        primed_r    <= (fill_next_s == cur_depth_r);
      end
    end
  end

  assign data_out  = data_out_r;
  assign out_valid = out_valid_r;
  assign primed    = primed_r;
  assign depth_err = depth_err_r;

endmodule
